// File: rtl/mem_port_arbiter_if.sv
// Handshake and memory bus bundle for mem_port_arbiter.
// slave = arbiter side, master = pipeline/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_ack_o;
    logic              d_read_i;
    logic              d_write_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic [DATA_W-1:0] d_rdata_o;
    logic              d_ack_o;
    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              stall_o;

    modport slave (
        input  if_req_i, if_addr_i,
        input  d_read_i, d_write_i, d_addr_i, d_wdata_i,
        input  mem_rdata_i,
        output if_rdata_o, if_ack_o,
        output d_rdata_o, d_ack_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output stall_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output d_read_i, d_write_i, d_addr_i, d_wdata_i,
        output mem_rdata_i,
        input  if_rdata_o, if_ack_o,
        input  d_rdata_o, d_ack_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  stall_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// IF/D arbiter for one fixed-latency single-port memory.
// Define ARB_RR_EN for alternating priority on contested grants.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    mem_port_arbiter_if.slave   bus
);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              own_d_q, own_d_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              d_req;
    logic              d_first;
    logic              pick_d;
    logic              if_ack, d_ack;

`ifdef ARB_RR_EN
    logic dfirst_q, dfirst_d;
    logic cont_q, cont_d;
    assign d_first = dfirst_q;
`else
    assign d_first = 1'b1;
`endif

    assign d_req  = bus.d_read_i | bus.d_write_i;
    assign pick_d = d_req & (~bus.if_req_i | d_first);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            own_d_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            own_d_q    <= own_d_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            dfirst_q <= 1'b1;
            cont_q   <= 1'b0;
        end else begin
            dfirst_q <= dfirst_d;
            cont_q   <= cont_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        own_d_d    = own_d_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
`ifdef ARB_RR_EN
        dfirst_d   = dfirst_q;
        cont_d     = cont_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (d_req | bus.if_req_i) begin
                    state_d = S_ACCESS;
                    cnt_d   = '0;
                    own_d_d = pick_d;
                    // read+write together is a write
                    we_d    = pick_d & bus.d_write_i;
                    addr_d  = pick_d ? bus.d_addr_i
                                     : bus.if_addr_i;
                    wdata_d = bus.d_wdata_i;
`ifdef ARB_RR_EN
                    cont_d  = d_req & bus.if_req_i;
`endif
                end
            end
            S_ACCESS: begin
                if (cnt_q == LAST) begin
                    state_d = S_RESP;
                    if (!we_q) begin
                        if (own_d_q)
                            d_rdata_d = bus.mem_rdata_i;
                        else
                            if_rdata_d = bus.mem_rdata_i;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
`ifdef ARB_RR_EN
                if (cont_q)
                    dfirst_d = ~dfirst_q;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign if_ack = (state_q == S_RESP) & ~own_d_q;
    assign d_ack  = (state_q == S_RESP) & own_d_q;

    assign bus.if_ack_o    = if_ack;
    assign bus.d_ack_o     = d_ack;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.d_rdata_o   = d_rdata_q;
    assign bus.mem_en_o    = (state_q == S_ACCESS);
    assign bus.mem_we_o    = (state_q == S_ACCESS) & we_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;
    // gated by reset so every output reads 0 while held
    assign bus.stall_o = rst_i
                       & (bus.if_req_i | d_req)
                       & ~(if_ack | d_ack);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (MEM_LAT=2).
// Transaction-timeline model plus directed literal checks.
module tb_mem_port_arbiter;
    localparam int LAT = 2;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] a;
        logic [31:0] w;
    } dreq_t;

    logic clk;
    logic rst_i;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .MEM_LAT (LAT)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // model: a transfer is a timeline of LAT access cycles then one ack cycle
    bit          mbusy;
    int          mt;
    bit          mown_d;
    bit          mwe;
    bit          mcont;
    bit          mdfirst;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] mrd_if;
    logic [31:0] mrd_d;
    logic [31:0] mmem [256];
    bit          mv   [256];

    wire m_dreq = bus.d_read_i | bus.d_write_i;
    wire m_pd   = m_dreq & (~bus.if_req_i | mdfirst);

    always @(posedge clk) begin
        if (!rst_i) begin
            mbusy    <= 1'b0;
            mt       <= 0;
            mrd_if   <= '0;
            mrd_d    <= '0;
            mdfirst  <= 1'b1;
            mcont    <= 1'b0;
            mmem[64] <= 32'hDEAD_BEEF;
            mv[64]   <= 1'b1;
        end else if (!mbusy) begin
            if (m_dreq | bus.if_req_i) begin
                mbusy  <= 1'b1;
                mt     <= 1;
                mown_d <= m_pd;
                mwe    <= m_pd & bus.d_write_i;
                maddr  <= m_pd ? bus.d_addr_i : bus.if_addr_i;
                mwdata <= bus.d_wdata_i;
                mcont  <= m_dreq & bus.if_req_i;
            end
        end else if (mt == LAT + 1) begin
            mbusy <= 1'b0;
`ifdef ARB_RR_EN
            if (mcont)
                mdfirst <= ~mdfirst;
`endif
        end else begin
            if (mt == LAT) begin
                if (mwe) begin
                    mmem[maddr[9:2]] <= mwdata;
                    mv[maddr[9:2]]   <= 1'b1;
                end else if (mown_d) begin
                    mrd_d <= mv[maddr[9:2]] ? mmem[maddr[9:2]]
                                            : dflt(maddr);
                end else begin
                    mrd_if <= mv[maddr[9:2]] ? mmem[maddr[9:2]]
                                             : dflt(maddr);
                end
            end
            mt <= mt + 1;
        end
    end

    int          checks;
    int          failures;
    int          cyc;
    int          kill_cyc;
    int          issue_if_cyc, issue_d_cyc;
    int          if_ack_cyc, d_ack_cyc;
    int          tot_en, tot_we, tot_stall, tot_ack;
    bit          if_ack_seen, d_ack_seen;
    logic [31:0] last_en_addr;
    logic [31:0] tbmem [256];
    bit          tbv   [256];
    logic [31:0] iq [$];
    dreq_t       dq [$];
    bit          ack_log [$];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return tbv[a[9:2]] ? tbmem[a[9:2]] : dflt(a);
    endfunction

    task automatic compare();
        bit e_en, e_we, e_ia, e_da, e_st;
        if (!rst_i) begin
            chk("rst_en", {31'd0, bus.mem_en_o}, 0);
            chk("rst_we", {31'd0, bus.mem_we_o}, 0);
            chk("rst_if_ack", {31'd0, bus.if_ack_o}, 0);
            chk("rst_d_ack", {31'd0, bus.d_ack_o}, 0);
            chk("rst_stall", {31'd0, bus.stall_o}, 0);
            chk("rst_addr", bus.mem_addr_o, 0);
            chk("rst_wdata", bus.mem_wdata_o, 0);
            chk("rst_if_rdata", bus.if_rdata_o, 0);
            chk("rst_d_rdata", bus.d_rdata_o, 0);
            return;
        end
        e_en = mbusy && mt >= 1 && mt <= LAT;
        e_we = e_en && mwe;
        e_ia = mbusy && mt == LAT + 1 && !mown_d;
        e_da = mbusy && mt == LAT + 1 && mown_d;
        e_st = (bus.if_req_i | bus.d_read_i | bus.d_write_i)
               && !(e_ia || e_da);
        chk("mem_en", {31'd0, bus.mem_en_o}, {31'd0, e_en});
        chk("mem_we", {31'd0, bus.mem_we_o}, {31'd0, e_we});
        chk("if_ack", {31'd0, bus.if_ack_o}, {31'd0, e_ia});
        chk("d_ack", {31'd0, bus.d_ack_o}, {31'd0, e_da});
        chk("stall", {31'd0, bus.stall_o}, {31'd0, e_st});
        chk("if_rdata", bus.if_rdata_o, mrd_if);
        chk("d_rdata", bus.d_rdata_o, mrd_d);
        if (e_en)
            chk("mem_addr", bus.mem_addr_o, maddr);
        if (e_we)
            chk("mem_wdata", bus.mem_wdata_o, mwdata);
    endtask

    task automatic cycle();
        dreq_t r;
        @(posedge clk);
        cyc++;
        #1;
        if (cyc == kill_cyc)
            rst_i = 1'b0;
        if (!rst_i) begin
            bus.if_req_i  = 1'b0;
            bus.d_read_i  = 1'b0;
            bus.d_write_i = 1'b0;
        end else begin
            if (if_ack_seen)
                bus.if_req_i = 1'b0;
            if (d_ack_seen) begin
                bus.d_read_i  = 1'b0;
                bus.d_write_i = 1'b0;
            end
            if (!bus.if_req_i && iq.size() > 0) begin
                bus.if_req_i  = 1'b1;
                bus.if_addr_i = iq.pop_front();
                issue_if_cyc  = cyc;
            end
            if (!(bus.d_read_i | bus.d_write_i) && dq.size() > 0) begin
                r = dq.pop_front();
                bus.d_read_i  = r.rd;
                bus.d_write_i = r.wr;
                bus.d_addr_i  = r.a;
                bus.d_wdata_i = r.w;
                issue_d_cyc   = cyc;
            end
            // a granted request's payload must no longer matter
            if (mbusy && !mown_d && bus.if_req_i)
                bus.if_addr_i = $urandom;
            if (mbusy && mown_d && (bus.d_read_i | bus.d_write_i)) begin
                bus.d_addr_i  = $urandom;
                bus.d_wdata_i = $urandom;
            end
        end
        bus.mem_rdata_i = (mbusy && mt == LAT && !mwe)
                        ? rd(bus.mem_addr_o)
                        : (32'hBAD0_0000 ^ 32'(cyc));
        @(negedge clk);
        compare();
        if_ack_seen = bus.if_ack_o;
        d_ack_seen  = bus.d_ack_o;
        if (bus.if_ack_o) begin
            if_ack_cyc = cyc;
            ack_log.push_back(1'b0);
            tot_ack++;
        end
        if (bus.d_ack_o) begin
            d_ack_cyc = cyc;
            ack_log.push_back(1'b1);
            tot_ack++;
        end
        if (bus.mem_en_o) begin
            tot_en++;
            last_en_addr = bus.mem_addr_o;
        end
        if (bus.mem_we_o)
            tot_we++;
        if (bus.stall_o)
            tot_stall++;
        if (rst_i && bus.mem_en_o && bus.mem_we_o) begin
            tbmem[bus.mem_addr_o[9:2]] = bus.mem_wdata_o;
            tbv[bus.mem_addr_o[9:2]]   = 1'b1;
        end
    endtask

    task automatic run(input int budget);
        int n = 0;
        while ((dq.size() > 0 || iq.size() > 0 || bus.if_req_i
                || bus.d_read_i || bus.d_write_i || mbusy)
               && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL timeout: got %0d cycles allowed %0d",
                     n, budget);
        end
        cycle();
    endtask

    task automatic push_d(input bit rdb, input bit wrb,
                          input logic [31:0] a,
                          input logic [31:0] w);
        dreq_t r;
        r.rd = rdb;
        r.wr = wrb;
        r.a  = a;
        r.w  = w;
        dq.push_back(r);
    endtask

    int s_en, s_we, s_st, s_ack;
    bit exp_order [6];

    task automatic snap();
        s_en  = tot_en;
        s_we  = tot_we;
        s_st  = tot_stall;
        s_ack = tot_ack;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        kill_cyc = -1;
        rst_i    = 1'b0;
        bus.if_req_i    = 1'b0;
        bus.if_addr_i   = '0;
        bus.d_read_i    = 1'b0;
        bus.d_write_i   = 1'b0;
        bus.d_addr_i    = '0;
        bus.d_wdata_i   = '0;
        bus.mem_rdata_i = '0;
        tbmem[64] = 32'hDEAD_BEEF;
        tbv[64]   = 1'b1;
        repeat (3) cycle();
        rst_i = 1'b1;
        repeat (2) cycle();

        // single fetch
        snap();
        iq.push_back(32'h100);
        run(40);
        chk("t1_lat", 32'(if_ack_cyc - issue_if_cyc), 3);
        chk("t1_rdata", bus.if_rdata_o, 32'hDEAD_BEEF);
        chk("t1_en_cycles", 32'(tot_en - s_en), 2);
        chk("t1_addr", last_en_addr, 32'h100);
        chk("t1_stall_cycles", 32'(tot_stall - s_st), 3);

        // simultaneous D read and fetch
        snap();
        push_d(1'b1, 1'b0, 32'h40, 32'h0);
        iq.push_back(32'h104);
        run(40);
        chk("t2_d_lat", 32'(d_ack_cyc - issue_d_cyc), 3);
        chk("t2_if_lat", 32'(if_ack_cyc - issue_if_cyc), 7);
        chk("t2_d_rdata", bus.d_rdata_o, 32'hC0DE_0040);
        chk("t2_if_rdata", bus.if_rdata_o, 32'hC0DE_0104);
        chk("t2_stall_cycles", 32'(tot_stall - s_st), 6);

        // write, then read back
        snap();
        push_d(1'b0, 1'b1, 32'h40, 32'h1234_5678);
        run(40);
        chk("t3_we_cycles", 32'(tot_we - s_we), 2);
        chk("t3_lat", 32'(d_ack_cyc - issue_d_cyc), 3);
        chk("t3_d_rdata_kept", bus.d_rdata_o, 32'hC0DE_0040);
        push_d(1'b1, 1'b0, 32'h40, 32'h0);
        run(40);
        chk("t3_readback", bus.d_rdata_o, 32'h1234_5678);

        // read and write together means write
        snap();
        push_d(1'b1, 1'b1, 32'h44, 32'hCAFE_F00D);
        run(40);
        chk("t6_we_cycles", 32'(tot_we - s_we), 2);
        chk("t6_d_rdata_kept", bus.d_rdata_o, 32'h1234_5678);
        push_d(1'b1, 1'b0, 32'h44, 32'h0);
        run(40);
        chk("t6_readback", bus.d_rdata_o, 32'hCAFE_F00D);

        // reset in the first access cycle
        snap();
        push_d(1'b0, 1'b1, 32'h80, 32'h5555_AAAA);
        for (int i = 0; i < 10 && dq.size() > 0; i++)
            cycle();
        kill_cyc = cyc + 1;
        cycle();
        chk("t4_we_drop", {31'd0, bus.mem_we_o}, 0);
        chk("t4_en_drop", {31'd0, bus.mem_en_o}, 0);
        cycle();
        rst_i = 1'b1;
        repeat (6) cycle();
        chk("t4_no_ack", 32'(tot_ack - s_ack), 0);
        push_d(1'b1, 1'b0, 32'h40, 32'h0);
        run(40);
        chk("t4_fresh_lat", 32'(d_ack_cyc - issue_d_cyc), 3);
        chk("t4_fresh_rdata", bus.d_rdata_o, 32'h1234_5678);

        // continuous contention
`ifdef ARB_RR_EN
        exp_order = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
        ack_log.delete();
        for (int i = 0; i < 3; i++) begin
            push_d(1'b1, 1'b0, 32'(8 + 4 * i), 32'h0);
            iq.push_back(32'(32'h180 + 4 * i));
        end
        run(100);
        chk("t5_acks", 32'(ack_log.size()), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < ack_log.size())
                chk($sformatf("t5_owner%0d", i),
                    {31'd0, ack_log[i]}, {31'd0, exp_order[i]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
